// File: rtl/lm_hub75_capture.sv
// HUB75 receive-side capture: synchronizes the panel pins, buffers each shifted line in a
// ping-pong RAM and presents latched lines over valid/ready. Optional CRC: LM_CAPTURE_CRC_EN.
module lm_hub75_capture #(
  parameter int unsigned COLUMNS     = 64,
  parameter int unsigned COL_BITS    = 6,
  parameter int unsigned ROW_BITS    = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned OE_CNT_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   matrix_clk,
  input  logic                   matrix_lat,
  input  logic                   matrix_OE,
  input  logic [ROW_BITS-1:0]    matrix_addr,
  input  logic [5:0]             matrix_rgb,
  output logic                   line_valid,
  input  logic                   line_ready,
  output logic [ROW_BITS-1:0]    line_addr,
  output logic [COL_BITS:0]      line_count,
  output logic [OE_CNT_BITS-1:0] oe_cycles,
  output logic [7:0]             line_crc,
  input  logic [COL_BITS-1:0]    rd_col,
  output logic [5:0]             rd_rgb,
  output logic                   overflow,
  output logic                   dropped
);

  localparam int unsigned SyncW   = 3 + ROW_BITS + 6;
  localparam int unsigned WarmMax = SYNC_STAGES + 1;
  localparam int unsigned WarmW   = $clog2(WarmMax + 1);
  localparam logic [SyncW-1:0]       SyncRst = {1'b1, {(SyncW - 1){1'b0}}};
  localparam logic [COL_BITS:0]      ColOne  = 1;
  localparam logic [COL_BITS:0]      ColMax  = COLUMNS[COL_BITS:0];
  localparam logic [OE_CNT_BITS-1:0] OeOne   = 1;
  localparam logic [WarmW-1:0]       WarmOne = 1;
  localparam logic [WarmW-1:0]       WarmEnd = WarmMax[WarmW-1:0];

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  // OE resets to its inactive level so the counter does not run during synchronizer fill.
  logic [SyncW-1:0]    sync_q [SYNC_STAGES];
  logic                s_oe_n, s_lat, s_clk;
  logic [ROW_BITS-1:0] s_addr;
  logic [5:0]          s_rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SyncRst;
    end else begin
      sync_q[0] <= {matrix_OE, matrix_lat, matrix_clk, matrix_addr, matrix_rgb};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {s_oe_n, s_lat, s_clk, s_addr, s_rgb} = sync_q[SYNC_STAGES-1];

  logic             clk_prev_q, lat_prev_q;
  logic [WarmW-1:0] warm_q;
  logic             edges_en, pix_edge, lat_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_q <= 1'b0;
      lat_prev_q <= 1'b0;
      warm_q     <= '0;
    end else begin
      clk_prev_q <= s_clk;
      lat_prev_q <= s_lat;
      if (!edges_en) warm_q <= warm_q + WarmOne;
    end
  end

  assign edges_en = (warm_q == WarmEnd);
  assign pix_edge = edges_en & s_clk & ~clk_prev_q;
  assign lat_edge = edges_en & s_lat & ~lat_prev_q;

  state_e                 state_q, state_d;
  logic                   load, drop;
  logic [COL_BITS:0]      wr_col_q, wr_col_d, count_now;
  logic                   wr_bank_q;
  logic                   col_ok, store;
  logic [OE_CNT_BITS-1:0] oe_cnt_q, oe_cnt_d;
  logic [5:0]             mem_q [2**(COL_BITS+1)];

  assign col_ok    = (wr_col_q < ColMax);
  assign store     = pix_edge & col_ok;
  // A pixel edge in the latch cycle still belongs to the line being latched.
  assign count_now = store ? wr_col_q + ColOne : wr_col_q;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (lat_edge) begin
          load    = 1'b1;
          state_d = StFull;
        end
      end
      StFull: begin
        if (lat_edge) begin
          load = line_ready;
          drop = ~line_ready;
        end else if (line_ready) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    wr_col_d = lat_edge ? '0 : count_now;
    oe_cnt_d = oe_cnt_q;
    if (lat_edge) begin
      oe_cnt_d = '0;
    end else if (!s_oe_n && (oe_cnt_q != '1)) begin
      oe_cnt_d = oe_cnt_q + OeOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      wr_col_q   <= '0;
      wr_bank_q  <= 1'b0;
      oe_cnt_q   <= '0;
      line_addr  <= '0;
      line_count <= '0;
      oe_cycles  <= '0;
      overflow   <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_col_q  <= wr_col_d;
      oe_cnt_q  <= oe_cnt_d;
      wr_bank_q <= wr_bank_q ^ load;
      if (pix_edge && !col_ok) overflow <= 1'b1;
      if (drop) dropped <= 1'b1;
      if (load) begin
        line_addr  <= s_addr;
        line_count <= count_now;
        oe_cycles  <= oe_cnt_q;
      end
    end
  end

  assign line_valid = (state_q == StFull);

  always_ff @(posedge clk) begin
    if (store) mem_q[{wr_bank_q, wr_col_q[COL_BITS-1:0]}] <= s_rgb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_rgb <= '0;
    end else begin
      rd_rgb <= mem_q[{~wr_bank_q, rd_col}];
    end
  end

`ifdef LM_CAPTURE_CRC_EN
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  logic [7:0] crc_q, crc_now, line_crc_q;

  assign crc_now = store ? crc8_step(crc_q, {2'b00, s_rgb}) : crc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q      <= 8'h00;
      line_crc_q <= 8'h00;
    end else begin
      crc_q <= lat_edge ? 8'h00 : crc_now;
      if (load) line_crc_q <= crc_now;
    end
  end

  assign line_crc = line_crc_q;
`else
  assign line_crc = 8'h00;
`endif

endmodule

// File: tb/tb_lm_hub75_capture.sv
// Self-checking bench for lm_hub75_capture: directed scenarios plus randomized lines checked
// against a queue-based line model.
module tb_lm_hub75_capture;
  localparam int COLUMNS     = 64;
  localparam int COL_BITS    = 6;
  localparam int ROW_BITS    = 5;
  localparam int SYNC_STAGES = 2;
  localparam int OE_CNT_BITS = 16;

  typedef logic [5:0] pix_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   matrix_clk = 1'b0, matrix_lat = 1'b0, matrix_OE = 1'b1;
  logic [ROW_BITS-1:0]    matrix_addr = '0;
  logic [5:0]             matrix_rgb = '0;
  logic                   line_valid, line_ready = 1'b0;
  logic [ROW_BITS-1:0]    line_addr;
  logic [COL_BITS:0]      line_count;
  logic [OE_CNT_BITS-1:0] oe_cycles;
  logic [7:0]             line_crc;
  logic [COL_BITS-1:0]    rd_col = '0;
  logic [5:0]             rd_rgb;
  logic                   overflow, dropped;

  lm_hub75_capture #(
    .COLUMNS(COLUMNS), .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS),
    .SYNC_STAGES(SYNC_STAGES), .OE_CNT_BITS(OE_CNT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .matrix_clk(matrix_clk), .matrix_lat(matrix_lat),
    .matrix_OE(matrix_OE), .matrix_addr(matrix_addr), .matrix_rgb(matrix_rgb),
    .line_valid(line_valid), .line_ready(line_ready), .line_addr(line_addr),
    .line_count(line_count), .oe_cycles(oe_cycles), .line_crc(line_crc),
    .rd_col(rd_col), .rd_rgb(rd_rgb), .overflow(overflow), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: pixels shifted since the last latch, and the line currently presented.
  pix_t pix_q[$];
  pix_t exp_pix[$];
  int   exp_addr, exp_count;
  logic [7:0] exp_crc;
  bit   exp_valid, exp_ovf, exp_drop;

  // Bit-serial CRC-8 (x^8+x^2+x+1) over the byte stream, MSB first.
  function automatic logic [7:0] crc_ref(input pix_t px[$]);
    logic [7:0] crc = 8'h00;
    logic [7:0] b;
`ifdef LM_CAPTURE_CRC_EN
    foreach (px[i]) begin
      b = {2'b00, px[i]};
      for (int k = 7; k >= 0; k--) begin
        logic fb;
        fb  = crc[7] ^ b[k];
        crc = {crc[6:0], 1'b0};
        if (fb) crc = crc ^ 8'h07;
      end
    end
`else
    b = 8'h00;
`endif
    return crc;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    pix_q.delete();
    exp_pix.delete();
    exp_addr = 0; exp_count = 0; exp_crc = 8'h00;
    exp_valid = 0; exp_ovf = 0; exp_drop = 0;
  endtask

  task automatic shift_pixel(input pix_t p);
    matrix_rgb = p;
    tick(1);
    matrix_clk = 1'b1;
    tick(2);
    matrix_clk = 1'b0;
    tick(1);
    pix_q.push_back(p);
  endtask

  // Ready is raised only in the cycle the synchronized latch edge is acted upon.
  task automatic latch(input int a, input bit rdy);
    matrix_addr = a[ROW_BITS-1:0];
    tick(1);
    matrix_lat = 1'b1;
    tick(SYNC_STAGES);
    line_ready = rdy;
    matrix_lat = 1'b0;
    tick(1);
    line_ready = 1'b0;
    tick(2);
    if (pix_q.size() > COLUMNS) exp_ovf = 1;
    if (!exp_valid || rdy) begin
      exp_pix.delete();
      for (int i = 0; i < pix_q.size() && i < COLUMNS; i++) exp_pix.push_back(pix_q[i]);
      exp_valid = 1;
      exp_addr  = a;
      exp_count = exp_pix.size();
      exp_crc   = crc_ref(exp_pix);
    end else begin
      exp_drop = 1;
    end
    pix_q.delete();
  endtask

  task automatic consume();
    line_ready = 1'b1;
    tick(1);
    line_ready = 1'b0;
    tick(1);
    exp_valid = 0;
  endtask

  task automatic read_line(input string tag);
    for (int c = 0; c < exp_count; c++) begin
      rd_col = c[COL_BITS-1:0];
      tick(1);
      tests_run++;
      if (rd_rgb !== exp_pix[c]) begin
        tests_failed++;
        $display("FAIL %s rd_rgb[%0d]: got %0h expected %0h", tag, c, rd_rgb, exp_pix[c]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    tests_run++;
    if ({line_valid, line_addr, line_count, oe_cycles, line_crc, rd_rgb, overflow, dropped}
        !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b a=%0d n=%0d oe=%0d crc=%0h rgb=%0h ovf=%b drop=%b expected all 0",
               line_valid, line_addr, line_count, oe_cycles, line_crc, rd_rgb, overflow, dropped);
    end
    rst = 1'b0;
    model_reset();
    tick(SYNC_STAGES + 3);
    tests_run++;
    if (line_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_valid: got %b expected 0", line_valid);
    end
  endtask

  task automatic test_full_line();
    for (int k = 0; k < COLUMNS; k++) shift_pixel(pix_t'(k));
    latch(5, 0);
    tests_run++;
    if (line_valid !== 1'b1 || line_addr !== 5 || line_count !== 64) begin
      tests_failed++;
      $display("FAIL full_line: got v=%b a=%0d n=%0d expected v=1 a=5 n=64",
               line_valid, line_addr, line_count);
    end
    tests_run++;
    if (line_crc !== exp_crc || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_line_crc_ovf: got crc=%0h ovf=%b expected crc=%0h ovf=0",
               line_crc, overflow, exp_crc);
    end
    read_line("full_line");
    consume();
    tests_run++;
    if (line_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL consume_valid: got %b expected 0", line_valid);
    end
  endtask

  task automatic test_random_lines();
    for (int l = 0; l < 6; l++) begin
      int n = $urandom_range(0, 70);
      int a = $urandom_range(0, 31);
      for (int k = 0; k < n; k++) shift_pixel(pix_t'($urandom));
      latch(a, 0);
      tests_run++;
      if (line_valid !== 1'b1 || line_addr !== exp_addr[ROW_BITS-1:0] || line_count !== exp_count
          || line_crc !== exp_crc || overflow !== exp_ovf) begin
        tests_failed++;
        $display("FAIL random_line%0d: got v=%b a=%0d n=%0d crc=%0h ovf=%b expected v=1 a=%0d n=%0d crc=%0h ovf=%b",
                 l, line_valid, line_addr, line_count, line_crc, overflow,
                 exp_addr, exp_count, exp_crc, exp_ovf);
      end
      read_line("random_line");
      consume();
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 70; k++) shift_pixel(pix_t'(k));
    latch(9, 0);
    tests_run++;
    if (line_count !== 64 || overflow !== 1'b1 || line_addr !== 9) begin
      tests_failed++;
      $display("FAIL overflow: got n=%0d ovf=%b a=%0d expected n=64 ovf=1 a=9",
               line_count, overflow, line_addr);
    end
    read_line("overflow");
    consume();
  endtask

  task automatic test_drop();
    for (int k = 0; k < 3; k++) shift_pixel(pix_t'($urandom));
    latch(1, 0);
    for (int k = 0; k < 5; k++) shift_pixel(pix_t'($urandom));
    latch(2, 0);
    tests_run++;
    if (dropped !== 1'b1 || line_valid !== 1'b1 || line_addr !== 1 || line_count !== 3) begin
      tests_failed++;
      $display("FAIL drop: got drop=%b v=%b a=%0d n=%0d expected drop=1 v=1 a=1 n=3",
               dropped, line_valid, line_addr, line_count);
    end
    read_line("drop");
    consume();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) shift_pixel(pix_t'($urandom));
    latch(11, 0);
    for (int k = 0; k < 7; k++) shift_pixel(pix_t'($urandom));
    latch(12, 1);
    tests_run++;
    if (line_valid !== 1'b1 || line_addr !== 12 || line_count !== 7 || line_crc !== exp_crc) begin
      tests_failed++;
      $display("FAIL back_to_back: got v=%b a=%0d n=%0d crc=%0h expected v=1 a=12 n=7 crc=%0h",
               line_valid, line_addr, line_count, line_crc, exp_crc);
    end
    read_line("back_to_back");
    consume();
  endtask

  task automatic test_oe_and_empty();
    latch(0, 0);
    tests_run++;
    if (line_valid !== 1'b1 || line_count !== 0 || line_addr !== 0) begin
      tests_failed++;
      $display("FAIL zero_clock_line: got v=%b n=%0d a=%0d expected v=1 n=0 a=0",
               line_valid, line_count, line_addr);
    end
    consume();
    matrix_OE = 1'b0;
    tick(100);
    matrix_OE = 1'b1;
    tick(3);
    latch(7, 0);
    tests_run++;
    if (oe_cycles !== 100) begin
      tests_failed++;
      $display("FAIL oe_low_100: got %0d expected 100", oe_cycles);
    end
    consume();
    latch(8, 0);
    tests_run++;
    if (oe_cycles !== 0) begin
      tests_failed++;
      $display("FAIL oe_high: got %0d expected 0", oe_cycles);
    end
    consume();
  endtask

  task automatic test_reset_midline();
    for (int k = 0; k < 2; k++) shift_pixel(pix_t'($urandom));
    latch(4, 0);
    for (int k = 0; k < 5; k++) shift_pixel(pix_t'($urandom));
    rst = 1'b1;
    tick(2);
    tests_run++;
    if ({line_valid, line_addr, line_count, oe_cycles, line_crc, rd_rgb, overflow, dropped}
        !== '0) begin
      tests_failed++;
      $display("FAIL midline_reset: got v=%b a=%0d n=%0d oe=%0d crc=%0h rgb=%0h ovf=%b drop=%b expected all 0",
               line_valid, line_addr, line_count, oe_cycles, line_crc, rd_rgb, overflow, dropped);
    end
    rst = 1'b0;
    model_reset();
    tick(SYNC_STAGES + 3);
    shift_pixel(6'h01);
    latch(3, 0);
    tests_run++;
    if (line_valid !== 1'b1 || line_count !== 1 || line_addr !== 3 || line_crc !== exp_crc
        || overflow !== 1'b0 || dropped !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_line: got v=%b n=%0d a=%0d crc=%0h ovf=%b drop=%b expected v=1 n=1 a=3 crc=%0h ovf=0 drop=0",
               line_valid, line_count, line_addr, line_crc, overflow, dropped, exp_crc);
    end
`ifdef LM_CAPTURE_CRC_EN
    tests_run++;
    if (line_crc !== 8'h07) begin
      tests_failed++;
      $display("FAIL crc_single_pixel: got %0h expected 07", line_crc);
    end
`endif
    read_line("post_reset");
    consume();
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_random_lines();
    test_overflow();
    test_drop();
    test_back_to_back();
    test_oe_and_empty();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
